parity_req_arbiter: RTL
=======================

// Module: parity_req_arbiter
// PURPOSE
//  Shares one 16-bit parity generator/checker between N_REQ requesters.
//  - A round-robin arbiter accepts one request at a time over a valid/ready handshake.
//  - The request is latched and the parity is computed in a registered stage.
//  - The result is returned with the requester ID over a valid/ready response port.
//  - Sits between bus-side clients and the shared parity datapath.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  DW     16  data width per request
//  IDW    2   response ID width; must satisfy 2**IDW >= N_REQ
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          synchronous reset, active low
//  req_valid  in   N_REQ      per-requester request valid
//  req_ready  out  N_REQ      one-hot accept pulse to the granted requester
//  req_data   in   N_REQ*DW   flattened data; requester i uses [i*DW +: DW]
//  req_mode   in   N_REQ      0 = generate, 1 = check
//  req_odd    in   N_REQ      0 = even parity sense, 1 = odd parity sense
//  req_pbit   in   N_REQ      received parity bit (check mode only)
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_id     out  IDW        index of the requester served
//  rsp_parity out  1          generated parity bit
//  rsp_err    out  1          check mismatch; 0 in generate mode
//  busy       out  1          high whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rst_n == 0 at a clk edge):
//    - state <= IDLE, rr_ptr <= 0.
//    - All outputs go to 0: req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err, busy.
//  - FSM states: IDLE -> CALC -> RESP -> IDLE.
//  - IDLE:
//    - If any req_valid is high, grant the first asserted requester found searching
//      rr_ptr, rr_ptr+1, ... (mod N_REQ).
//    - req_ready[g] is asserted combinationally for that cycle only; the handshake
//      completes in that cycle.
//    - Latch data/mode/odd/pbit/id of requester g, set rr_ptr <= (g+1) mod N_REQ,
//      and go to CALC.
//    - With no req_valid, stay in IDLE.
//  - CALC (1 cycle):
//    - p = ^data when even sense, ~^data when odd sense.
//    - Generate mode: rsp_parity <= p, rsp_err <= 0.
//    - Check mode: rsp_parity <= p, rsp_err <= (p != pbit).
//    - Go to RESP.
//  - RESP:
//    - rsp_valid = 1; rsp_id, rsp_parity and rsp_err are held stable.
//    - Move to IDLE on the cycle rsp_valid && rsp_ready.
//    - No new request is accepted while in RESP.
//  - Timing:
//    - Latency: accept at cycle T -> rsp_valid at T+2.
//    - Best-case throughput is one request per 3 cycles.
//  - A requester must hold its valid and data stable until req_ready; data is
//    sampled only in the accept cycle.
//  - A requester dropping req_valid before grant is legal; it is simply skipped.
//  - Reset mid-operation (CALC or RESP) returns to IDLE with no response; the
//    pending result is discarded.
//  - All requesters valid continuously -> strict rotation 0,1,..,N_REQ-1,0,...
//    No requester waits more than N_REQ grants.
// CONFIGURATION
//  PARITY_ERR_CNT_EN
//  - Defined:
//    - Adds output err_cnt [7:0].
//    - Increments on each completed response (rsp_valid && rsp_ready) with rsp_err = 1.
//    - Saturates at 8'hFF; reset value 0.
//    - Adds input err_cnt_clr [1]; a synchronous clear that has priority over increment.
//  - Undefined: neither port nor counter exists; behaviour is otherwise identical.
// STRUCTURE
//  - Package parity_pkg:
//    - MODE_GEN = 1'b0, MODE_CHK = 1'b1.
//    - State encoding localparams ST_IDLE, ST_CALC, ST_RESP (2-bit).
//    - Function rr_pick(valid, ptr) returning the grant index.
//  - Sub-module parity_core (combinational):
//    - in [DW-1:0], odd -> parity.
//    - Instantiated once in CALC; the arbiter FSM lives in parity_req_arbiter.
// TESTING
//  1. Requester 0 only, gen, even, data 16'h0001
//     -> accept T, rsp_valid T+2, rsp_id 0, rsp_parity 1, rsp_err 0.
//  2. Requester 2, check, odd, data 16'h000A, pbit 1
//     -> rsp_parity 1, rsp_err 0.
//     Same with pbit 0 -> rsp_err 1 (and err_cnt 1 when PARITY_ERR_CNT_EN).
//  3. All four valid from reset, rsp_ready = 1, data 16'h000B, 16'h0009, 16'h0005, 16'h0004, even gen
//     -> rsp_id order 0,1,2,3; parity 1,0,0,1.
//  4. rsp_ready held 0 for 5 cycles in RESP (data 16'h000F)
//     -> rsp_valid and outputs stable, req_ready stays 0, busy 1.
//     Release -> IDLE the next cycle.
//  5. rst_n asserted during CALC
//     -> next cycle all outputs 0, no rsp_valid.
//     rr_ptr restarts at 0 (requester 0 wins over 3 when both valid).
//  6. Requester 1 deasserts valid before grant while 3 is valid
//     -> requester 3 granted, no response with rsp_id 1.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, state encoding and round-robin pick for the parity arbiter
package parity_pkg;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_RESP = ST_RESP
  } state_e;

  // First asserted requester at or after ptr, wrapping at n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  g;
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!found && (i < n) && valid[idx[2:0]]) begin
        g     = idx[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/parity_req_arbiter_if.sv
// rtl/parity_req_arbiter_if.sv - request/response bundle between clients and the parity arbiter
interface parity_req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_mode;
  logic [N_REQ-1:0]    req_odd;
  logic [N_REQ-1:0]    req_pbit;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_parity;
  logic                rsp_err;

  modport master (
    output req_valid, req_data, req_mode, req_odd, req_pbit, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_mode, req_odd, req_pbit, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err
  );
endinterface

// File: rtl/parity_core.sv
// rtl/parity_core.sv - combinational parity of one data word with selectable even/odd sense
module parity_core #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] in,
  input  logic          odd,
  output logic          parity
);
  assign parity = (^in) ^ odd;
endmodule

// File: rtl/parity_req_arbiter.sv
// rtl/parity_req_arbiter.sv - round-robin arbiter sharing one parity core; PARITY_ERR_CNT_EN adds err_cnt
module parity_req_arbiter
  import parity_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_req_arbiter_if.slave  bus,
  output logic                 busy
`ifdef PARITY_ERR_CNT_EN
  ,
  input  logic                 err_cnt_clr,
  output logic [7:0]           err_cnt
`endif
);

  localparam logic [2:0] LAST = 3'(N_REQ - 1);

  state_e         state_q, state_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           mode_q, mode_d;
  logic           odd_q, odd_d;
  logic           pbit_q, pbit_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_parity_q, rsp_parity_d;
  logic           rsp_err_q, rsp_err_d;

  logic [2:0]       grant;
  logic             any_valid;
  logic [N_REQ-1:0] req_ready;
  logic [DW-1:0]    sel_data;
  logic             sel_mode, sel_odd, sel_pbit;
  logic             parity;

  assign any_valid = |bus.req_valid;
  assign grant     = rr_pick(8'(bus.req_valid), rr_ptr_q, N_REQ);

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    sel_odd  = 1'b0;
    sel_pbit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 3'(i)) begin
        sel_data = bus.req_data[i*DW +: DW];
        sel_mode = bus.req_mode[i];
        sel_odd  = bus.req_odd[i];
        sel_pbit = bus.req_pbit[i];
      end
    end
  end

  parity_core #(.DW(DW)) u_core (
    .in     (data_q),
    .odd    (odd_q),
    .parity (parity)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    data_d       = data_q;
    mode_d       = mode_q;
    odd_d        = odd_q;
    pbit_d       = pbit_q;
    rsp_id_d     = rsp_id_q;
    rsp_parity_d = rsp_parity_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    case (state_q)
      S_IDLE: begin
        // Grant is suppressed during reset so no client sees a handshake that gets dropped.
        if (any_valid && rst_n) begin
          req_ready = N_REQ'(1) << grant;
          data_d    = sel_data;
          mode_d    = sel_mode;
          odd_d     = sel_odd;
          pbit_d    = sel_pbit;
          rsp_id_d  = IDW'(grant);
          rr_ptr_d  = (grant == LAST) ? 3'd0 : grant + 3'd1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rsp_parity_d = parity;
        rsp_err_d    = (mode_q == MODE_CHK) && (parity != pbit_q);
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      odd_q        <= 1'b0;
      pbit_q       <= 1'b0;
      rsp_id_q     <= '0;
      rsp_parity_q <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      odd_q        <= odd_d;
      pbit_q       <= pbit_d;
      rsp_id_q     <= rsp_id_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_parity = rsp_parity_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != S_IDLE);

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if ((state_q == S_RESP) && bus.rsp_ready && rsp_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
